// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store at a time, a fixed access
// latency, and valid/ready request and response channels around a doubleword array.
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  // Handshake rule on both channels: a transfer happens on a rising edge where
  // valid && ready are both high; the sender holds its payload stable until then.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;

  logic [63:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          addr_err;
  logic          commit;

  assign idx       = r_addr[3 +: AW];
  assign addr_err  = (r_addr[2:0] != 3'b000) || (r_addr >= ADDR_LIMIT);
  assign commit    = (state == BUSY) && (cnt == 4'd0);
  assign req_ready = (state == IDLE);

  // BUSY always lasts LATENCY cycles (one cycle when LATENCY=1), so the access and
  // rsp_valid land exactly LATENCY edges after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 64'd0;
      r_wdata   <= 64'd0;
      r_wstrb   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= addr_err;
            rsp_rdata <= (addr_err || r_we) ? 64'd0 : mem[idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store commit; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && r_we && !addr_err) begin
      for (int i = 0; i < 8; i++) begin
        if (r_wstrb[i]) mem[idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the responder.
module tb_data_mem_responder;

  localparam int DEPTH   = 128;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_wstrb = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------- transaction-level model ----------------
  logic [63:0] model_mem [DEPTH];
  logic [63:0] exp_q [$];   // expected rdata of each response, in order
  bit          m_started = 0;
  bit          m_busy = 0;
  bit          m_valid = 0;
  logic [63:0] m_rdata = 64'd0;
  bit          m_err = 0;
  int          m_due = 0;
  int          cyc = 0;
  bit          p_store = 0;
  int          p_idx = 0;
  logic [63:0] p_wdata;
  logic [7:0]  p_wstrb;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_started = 1;
      m_busy    = 0;
      m_valid   = 0;
      p_store   = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  = 1;
        m_due   = cyc + LATENCY;
        m_err   = (req_addr % 8 != 0) || (req_addr >= 64'(DEPTH * 8));
        p_store = req_we && !m_err;
        p_idx   = int'(req_addr / 8);
        p_wdata = req_wdata;
        p_wstrb = req_wstrb;
        m_rdata = (m_err || req_we) ? 64'd0 : model_mem[p_idx];
      end
    end else if (m_valid) begin
      if (rsp_ready) begin
        m_busy  = 0;
        m_valid = 0;
      end
    end else if (cyc == m_due) begin
      m_valid = 1;
      exp_q.push_back(m_rdata);
      if (p_store) begin
        for (int i = 0; i < 8; i++)
          if (p_wstrb[i]) model_mem[p_idx][8*i +: 8] = p_wdata[8*i +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (m_started) begin
      chk("req_ready", 64'(req_ready), 64'(!m_busy));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a request and return once the acceptance edge has passed (+1).
  task automatic send(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] wstrb);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    n = 0;
    #4;
    while (!req_ready && n < 50) begin
      @(posedge clk); #4; n++;
    end
    if (n >= 50) chk("accept_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
  endtask

  // Wait for the response, hold it for 'hold' cycles with junk requests, then take it.
  task automatic recv(input int hold, output logic [63:0] rdata, output logic err,
                      output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 40) chk("rsp_timeout", 64'(lat), 64'd0);
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 64'($urandom_range(0, 127)) * 8;
      req_wdata = {$urandom, $urandom};
      req_wstrb = 8'hFF;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wstrb, input int hold,
                        output logic [63:0] rdata, output logic err, output int lat);
    send(we, addr, wdata, wstrb);
    recv(hold, rdata, err, lat);
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 64'($urandom_range(0, 127)) * 8 + 64'($urandom_range(1, 7));
      1: return 64'(DEPTH * 8) + 64'($urandom_range(0, 300)) * 8;
      2: return {$urandom, 32'd0};
      default: return 64'($urandom_range(0, 15)) * 8;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    logic [63:0] m0_before;

    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = {$urandom, $urandom};
      dut.mem[i]   = model_mem[i];
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", rsp_rdata, 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b0;
    #4;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // 1: full store then load back
    do_req(1'b1, 64'h200, 64'hB, 8'hFF, 0, rd, er, lat);
    chk("t1_store_lat", 64'(lat), 64'(LATENCY));
    chk("t1_store_err", 64'(er), 64'd0);
    chk("t1_store_rdata", rd, 64'd0);
    do_req(1'b0, 64'h200, 64'd0, 8'h00, 0, rd, er, lat);
    chk("t1_load_rdata", rd, 64'h000000000000000B);
    chk("t1_mem64", dut.mem[64], 64'hB);
    chk("t1_model_mem64", model_mem[64], 64'hB);

    // 2: preload and load
    dut.mem[32] = 64'h1234567890ABCDEF;
    model_mem[32] = 64'h1234567890ABCDEF;
    do_req(1'b0, 64'h100, 64'd0, 8'h00, 0, rd, er, lat);
    chk("t2_rdata", rd, 64'h1234567890ABCDEF);
    chk("t2_err", 64'(er), 64'd0);
    chk("t2_lat", 64'(lat), 64'(LATENCY));

    // 3: partial store
    do_req(1'b1, 64'h100, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 0, rd, er, lat);
    do_req(1'b0, 64'h100, 64'd0, 8'h00, 0, rd, er, lat);
    chk("t3_partial", rd, 64'h12345678FFFFFFFF);

    // 3b: empty strobe is a legal no-op
    do_req(1'b1, 64'h100, 64'h0, 8'h00, 0, rd, er, lat);
    chk("t3b_err", 64'(er), 64'd0);
    chk("t3b_mem32", dut.mem[32], 64'h12345678FFFFFFFF);

    // 4: backpressure with junk requests; no re-accept on handshake edge
    send(1'b0, 64'h100, 64'd0, 8'h00);
    recv(5, rd, er, lat);
    chk("t4_rdata", rd, 64'h12345678FFFFFFFF);
    chk("t4_ready_after", 64'(req_ready), 64'd1);

    // 5: errors
    do_req(1'b0, 64'h104, 64'd0, 8'h00, 0, rd, er, lat);
    chk("t5_misaligned_err", 64'(er), 64'd1);
    chk("t5_misaligned_rdata", rd, 64'd0);
    m0_before = dut.mem[0];
    do_req(1'b1, 64'h400, 64'hDEAD, 8'hFF, 0, rd, er, lat);
    chk("t5_oor_err", 64'(er), 64'd1);
    chk("t5_mem0", dut.mem[0], m0_before);
    chk("t5_mem64", dut.mem[64], 64'hB);

    // 6: reset while the store is still pending
    send(1'b1, 64'h200, 64'h77, 8'hFF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_req_ready", 64'(req_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_mem64", dut.mem[64], 64'hB);
    do_req(1'b0, 64'h200, 64'd0, 8'h00, 0, rd, er, lat);
    chk("t6_load", rd, 64'hB);

    // random traffic; model compare runs every cycle
    for (int t = 0; t < 300; t++) begin
      do_req(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
             8'($urandom_range(0, 255)), $urandom_range(0, 3), rd, er, lat);
      chk("rand_lat", 64'(lat), 64'(LATENCY));
      if (exp_q.size() == 0) chk("rand_expq_empty", 64'd0, 64'd1);
      else chk("rand_rdata", rd, exp_q[$]);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    for (int i = 0; i < DEPTH; i++) chk("final_mem", dut.mem[i], model_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
